sd_readout_chunker: RTL and testbench
=====================================

// Module: sd_readout_chunker
// PURPOSE
//  Sits between the SD DAT readout (16-bit words from the SD block reader) and
//  the STM SPI byte-output path. Buffers readout data in two ping-pong banks of
//  CHUNK_WORDS words each. Asserts a "chunk ready" flag (drives
//  ice_stm_spi_d_ready) only when a whole bank is full, so the STM can burst-read
//  a chunk with no per-byte flow control. The SD side keeps filling the other
//  bank while the STM drains. Single clock domain; CDC is handled upstream.
// PARAMETERS
//  CHUNK_WORDS  256  words per bank; a chunk is 2*CHUNK_WORDS bytes (one 512B SD block); power of 2, >=2
// PORTS
//  clk           in   1   clock; the only clock
//  rst           in   1   synchronous active-high reset
//  w_data        in   16  upstream readout word
//  w_valid       in   1   w_data valid
//  w_ready       out  1   chunker can accept; a transfer occurs when w_valid && w_ready
//  out_ready     out  1   a full chunk is available and no byte of it has been consumed yet
//  out_data      out  8   current byte at the read pointer
//  out_trigger   in   1   consume out_data this cycle
//  out_underflow out  1   sticky: out_trigger seen while no chunk was full
// BEHAVIOUR
//  - Reset: both banks empty, w_bank=0, r_bank=0, pointers=0, w_ready=1, out_ready=0,
//    out_data=8'h00, out_underflow=0. Reset mid-fill or mid-drain discards all buffered data.
//  - Bank state: full[b] is set on the cycle after the CHUNK_WORDS-th word is accepted into
//    bank b. It is cleared on the cycle after the last byte of bank b is consumed.
//    w_ptr/r_ptr wrap to 0 and the bank index toggles at the same edge.
//  - Write side: w_ready = !full[w_bank]. Words are stored in order. w_valid with w_ready=0
//    is held by upstream, not dropped.
//  - Read side states: IDLE (full[r_bank]=0), READY (full, r_ptr=0), DRAIN (0<r_ptr<2*CHUNK_WORDS).
//    - IDLE->READY when full[r_bank] rises. out_ready=1 only in READY.
//    - READY->DRAIN on the first out_trigger.
//    - DRAIN->READY/IDLE on the last byte, depending on full[other bank].
//      If the other bank is already full, out_ready reasserts the cycle after the last byte.
//  - Byte order: little-endian per word (bits[7:0], then [15:8]).
//  - out_data shows the byte at r_ptr whenever full[r_bank]=1. After out_trigger at cycle N,
//    the next byte is on out_data at N+1, so back-to-back triggers every cycle are legal.
//    A one-word prefetch register hides RAM read latency.
//  - Underflow: out_trigger while full[r_bank]=0 sets out_underflow (cleared only by rst),
//    does not move r_ptr, and out_data reads 8'h00.
//  - Simultaneous events:
//    - Write into bank X and drain of bank Y in the same cycle are independent.
//    - The cycle full[r_bank] clears, w_ready for that bank may rise; a word accepted that
//      cycle lands at w_ptr=0 of the freed bank.
//  - Latency from the last accepted word to out_ready is 1 cycle (bank empty, read side IDLE).
// TESTING
//  1. rst; send words 0x0000..0x00FF, 1/cycle -> out_ready=1 exactly 1 cycle after the
//     256th accept; w_ready stays 1 (bank 1 free).
//  2. Drain 512 triggers back-to-back -> bytes 00,00,01,00,...,FF,00.
//     out_ready drops the cycle after the 1st trigger; out_underflow=0.
//  3. Fill bank0 and bank1 (words 0x1000+i) without draining -> w_ready=0 after 512 accepts.
//     Drain bank0 -> out_ready=1 the cycle after the last byte; first byte 8'h00, then 8'h10.
//  4. w_valid toggling 50% plus random out_trigger gaps over 8 chunks -> output byte stream
//     equals the input word stream LE-split; no loss or duplication.
//  5. out_trigger with no full bank -> out_underflow=1, out_data=00, r_ptr unchanged.
//     The flag persists until rst.
//  6. rst asserted mid-drain at byte 100 -> next cycle out_ready=0, w_ready=1, out_underflow=0.
//     A fresh 256-word fill reads back from word 0.

Source files
------------

// File: rtl/sd_readout_chunker.sv
// Ping-pong word buffer between the SD block reader and the STM SPI byte path.
// A chunk is offered only when a whole bank is full, so the STM can burst-read it.
//
// state   | meaning
// S_IDLE  | bank at r_bank is not full; nothing to offer, triggers are underflows
// S_READY | full chunk waiting at r_bank, no byte of it consumed yet
// S_DRAIN | chunk at r_bank partly consumed
module sd_readout_chunker #(
  parameter int CHUNK_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] w_data,
  input  logic        w_valid,
  output logic        w_ready,
  output logic        out_ready,
  output logic [7:0]  out_data,
  input  logic        out_trigger,
  output logic        out_underflow
);

  localparam int WW = $clog2(CHUNK_WORDS);
  localparam int AW = WW + 1;
  localparam logic [WW-1:0] W_LAST = WW'(CHUNK_WORDS - 1);
  localparam logic [AW-1:0] R_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_DRAIN = 2'd2
  } rd_state_e;

  logic [15:0]   mem_q [2*CHUNK_WORDS];
  logic [15:0]   pf_q;
  logic [1:0]    full_q, full_d;
  logic          w_bank_q, w_bank_d;
  logic          r_bank_q, r_bank_d;
  logic [WW-1:0] w_ptr_q, w_ptr_d;
  logic [AW-1:0] r_ptr_q, r_ptr_d;
  logic          w_ready_q, w_ready_d;
  logic          underflow_q, underflow_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic          wr_fire, rd_fire;
  logic [AW-1:0] wr_addr, rd_addr;

  always_comb begin
    wr_fire     = w_valid && w_ready_q;
    rd_fire     = out_trigger && full_q[r_bank_q];
    full_d      = full_q;
    w_bank_d    = w_bank_q;
    w_ptr_d     = w_ptr_q;
    r_bank_d    = r_bank_q;
    r_ptr_d     = r_ptr_q;
    underflow_d = underflow_q | (out_trigger && !full_q[r_bank_q]);

    // Writer only ever targets a non-full bank and the reader a full one,
    // so the two updates below never touch the same bank.
    if (wr_fire) begin
      if (w_ptr_q == W_LAST) begin
        full_d[w_bank_q] = 1'b1;
        w_bank_d         = ~w_bank_q;
        w_ptr_d          = '0;
      end else begin
        w_ptr_d = w_ptr_q + WW'(1);
      end
    end

    if (rd_fire) begin
      if (r_ptr_q == R_LAST) begin
        full_d[r_bank_q] = 1'b0;
        r_bank_d         = ~r_bank_q;
        r_ptr_d          = '0;
      end else begin
        r_ptr_d = r_ptr_q + AW'(1);
      end
    end

    w_ready_d = !full_d[w_bank_d];

    if (!full_d[r_bank_d]) begin
      rd_state_d = S_IDLE;
    end else if (r_ptr_d == '0) begin
      rd_state_d = S_READY;
    end else begin
      rd_state_d = S_DRAIN;
    end

    wr_addr = {w_bank_q, w_ptr_q};
    rd_addr = {r_bank_d, r_ptr_d[AW-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      w_bank_q    <= 1'b0;
      w_ptr_q     <= '0;
      r_bank_q    <= 1'b0;
      r_ptr_q     <= '0;
      w_ready_q   <= 1'b1;
      underflow_q <= 1'b0;
      rd_state_q  <= S_IDLE;
    end else begin
      full_q      <= full_d;
      w_bank_q    <= w_bank_d;
      w_ptr_q     <= w_ptr_d;
      r_bank_q    <= r_bank_d;
      r_ptr_q     <= r_ptr_d;
      w_ready_q   <= w_ready_d;
      underflow_q <= underflow_d;
      rd_state_q  <= rd_state_d;
    end
  end

  // pf_q is fetched from next cycle's read address, so it always holds the word
  // under r_ptr. A word being written can never be the one under a full bank's r_ptr.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem_q[wr_addr] <= w_data;
    end
    pf_q <= mem_q[rd_addr];
  end

  assign w_ready       = w_ready_q;
  assign out_ready     = (rd_state_q == S_READY);
  assign out_underflow = underflow_q;
  assign out_data      = full_q[r_bank_q] ? (r_ptr_q[0] ? pf_q[15:8] : pf_q[7:0]) : 8'h00;

endmodule

// File: tb/tb_sd_readout_chunker.sv
// Randomized and directed bench for sd_readout_chunker against a chunk-count model.
module tb_sd_readout_chunker;

  localparam int CW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_trigger;
  logic        out_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words accepted and bytes consumed since reset; chunks drain in order.
  int unsigned acc;
  int unsigned cons;
  logic [15:0] words[$];
  bit          uf_m;
  bit          last_wfire;

  sd_readout_chunker #(.CHUNK_WORDS(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .w_data        (w_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_trigger   (out_trigger),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pending();
    return int'(acc / CW) - int'(cons / (2 * CW));
  endfunction

  function automatic logic [7:0] exp_byte(input int unsigned k);
    logic [15:0] w;
    w = words[k / 2];
    return (k % 2) ? w[15:8] : w[7:0];
  endfunction

  task automatic step(input logic r, input logic wv, input logic [15:0] wd, input logic trig);
    int p;
    bit wfire, rfire, uf;
    rst         = r;
    w_valid     = wv;
    w_data      = wd;
    out_trigger = trig;
    p     = pending();
    wfire = !r && wv && (p < 2);
    rfire = !r && trig && (p > 0);
    uf    = !r && trig && (p == 0);
    @(posedge clk);
    if (r) begin
      acc  = 0;
      cons = 0;
      words.delete();
      uf_m = 1'b0;
    end else begin
      if (wfire) begin
        words.push_back(wd);
        acc++;
      end
      if (rfire) cons++;
      if (uf) uf_m = 1'b1;
    end
    last_wfire = wfire;
    #1;
    p = pending();
    chk("w_ready", 32'(w_ready), 32'(p < 2));
    chk("out_ready", 32'(out_ready), 32'((p > 0) && (cons % (2 * CW) == 0)));
    chk("out_data", 32'(out_data), (p > 0) ? 32'(exp_byte(cons)) : 32'd0);
    chk("out_underflow", 32'(out_underflow), 32'(uf_m));
  endtask

  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 16'(i), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    bit          have;
    logic [15:0] cur;
    int          sent;
    bit          done;
    logic        trig;

    acc = 0; cons = 0; uf_m = 1'b0; last_wfire = 1'b0;
    rst = 1'b1; w_valid = 1'b0; w_data = '0; out_trigger = 1'b0;

    // reset values
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'h0);

    // 1: one bank of 0x0000..0x00FF; out_ready rises 1 cycle after last accept
    fill(CW - 1, 16'h0000);
    chk("t1_not_ready_early", 32'(out_ready), 32'd0);
    fill(1, 16'(CW - 1));
    chk("t1_ready", 32'(out_ready), 32'd1);
    chk("t1_wready", 32'(w_ready), 32'd1);

    // 2: back-to-back drain
    drain(1);
    chk("t2_ready_drop", 32'(out_ready), 32'd0);
    drain(2 * CW - 1);
    chk("t2_underflow", 32'(out_underflow), 32'd0);

    // 3: both banks full, then drain bank 0
    fill(2 * CW, 16'h1000);
    chk("t3_wready_full", 32'(w_ready), 32'd0);
    chk("t3_first_byte", 32'(out_data), 32'h00);
    drain(1);
    chk("t3_second_byte", 32'(out_data), 32'h10);
    drain(2 * CW - 1);
    chk("t3_ready_again", 32'(out_ready), 32'd1);
    drain(2 * CW);

    // 4: random valid / trigger over 8 chunks
    step(1'b1, 1'b0, 16'h0, 1'b0);
    have = 1'b0; cur = '0; sent = 0; done = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (!have && sent < 8 * CW && $urandom_range(1, 0) == 1) begin
        have = 1'b1;
        cur  = 16'($urandom);
      end
      trig = (pending() > 0) && ($urandom_range(3, 0) != 0);
      step(1'b0, have, cur, trig);
      if (last_wfire) begin
        have = 1'b0;
        sent++;
      end
      if (acc == 8 * CW && cons == 2 * acc) begin
        done = 1'b1;
        break;
      end
    end
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_bytes", cons, 32'(16 * CW));

    // 5: underflow with nothing full, sticky until reset
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t5_underflow", 32'(out_underflow), 32'd1);
    chk("t5_data", 32'(out_data), 32'h0);
    fill(CW, 16'h5A00);
    chk("t5_ptr_kept", 32'(out_data), 32'h00);
    drain(1);
    chk("t5_ptr_kept_hi", 32'(out_data), 32'h5A);
    drain(2 * CW - 1);
    chk("t5_sticky", 32'(out_underflow), 32'd1);

    // 6: reset mid-drain, then a fresh fill reads back from word 0
    fill(CW, 16'h7700);
    drain(100);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_ready", 32'(out_ready), 32'd0);
    chk("t6_wready", 32'(w_ready), 32'd1);
    chk("t6_underflow", 32'(out_underflow), 32'd0);
    fill(CW, 16'h3300);
    chk("t6_word0_lo", 32'(out_data), 32'h00);
    drain(1);
    chk("t6_word0_hi", 32'(out_data), 32'h33);
    drain(2 * CW - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
